cpu_ula_issue: RTL and testbench

Initiator for the CPU's ALU handshake. Accepts one 16-bit instruction at a time, reads operands from an internal 8×16 register file and drives `op_code`/`src1`/`src2` into the ALU. It then waits for the ALU's `done` and writes the result back. It sits between instruction fetch and the ALU, and is the only block that drives the ALU inputs.

---
 rtl/cpu_ula_issue_pkg.sv | 49 ++++
 rtl/cpu_ula_issue_if.sv | 21 ++
 rtl/cpu_ula_issue_regfile.sv | 42 ++++
 rtl/cpu_ula_issue.sv | 158 +++++++++++++++
 tb/tb_cpu_ula_issue.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ula_issue_pkg.sv
// cpu_pkg: shared constants for the ALU issue block -- opcodes, instruction
// field positions, FSM state encoding and register-file geometry.
package cpu_pkg;

  // Register file geometry
  localparam int RF_DEPTH = 8;
  localparam int RF_WIDTH = 16;
  localparam int RF_AW    = 3;

  // Opcodes (110 and 111 are illegal)
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SUBI = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;

  // Instruction field bit positions; imm7 overlaps rs2 and the pad bits
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 7;
  localparam int RS2_MSB = 6;
  localparam int RS2_LSB = 4;
  localparam int IMM_MSB = 6;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WB    = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Opcodes that are handed to the ALU
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_SUB) ||
           (op == OP_SUBI) || (op == OP_MUL);
  endfunction

  // Opcodes whose second operand is the raw imm7 field
  function automatic logic uses_imm(input logic [2:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI);
  endfunction

endpackage

// File: rtl/cpu_ula_issue_if.sv
// cpu_ula_issue_if: request/completion bus between the issue block (master)
// and the ALU (slave).
interface cpu_ula_issue_if;
  import cpu_pkg::*;

  logic [2:0]          alu_op_code;
  logic [RF_WIDTH-1:0] alu_src1;
  logic [RF_WIDTH-1:0] alu_src2;
  logic                alu_done;
  logic [RF_WIDTH-1:0] alu_result;

  modport master (
    output alu_op_code, alu_src1, alu_src2,
    input  alu_done, alu_result
  );

  modport slave (
    input  alu_op_code, alu_src1, alu_src2,
    output alu_done, alu_result
  );
endinterface

// File: rtl/cpu_ula_issue_regfile.sv
// cpu_regfile: 8x16 register file, two operand read ports, one write port,
// one debug read port. R0 is a constant zero; R1-R7 clear on reset.
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [RF_AW-1:0]    waddr,
  input  logic [RF_WIDTH-1:0] wdata,
  input  logic [RF_AW-1:0]    raddr_a,
  input  logic [RF_AW-1:0]    raddr_b,
  input  logic [RF_AW-1:0]    dbg_addr,
  output logic [RF_WIDTH-1:0] rdata_a,
  output logic [RF_WIDTH-1:0] rdata_b,
  output logic [RF_WIDTH-1:0] dbg_data
);

  logic [RF_WIDTH-1:0] regs [RF_DEPTH];

  for (genvar gi = 0; gi < RF_DEPTH; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign regs[gi] = '0;
    end else begin : g_store
      logic [RF_WIDTH-1:0] r_q;
      // One register; async clear so reset discards everything at once
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_q <= '0;
        end else if (we && (waddr == RF_AW'(gi))) begin
          r_q <= wdata;
        end
      end
      assign regs[gi] = r_q;
    end
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/cpu_ula_issue.sv
// cpu_ula_issue: issues one instruction at a time to the ALU, waits for
// alu_done and writes the result back into the local register file.
// Optional WAIT watchdog enabled by defining CPU_ULA_ISSUE_TIMEOUT_EN.
module cpu_ula_issue
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  input  logic [15:0]         instr,
  output logic                instr_ready,
  output logic                retire,
  output logic                err,
  input  logic [RF_AW-1:0]    dbg_addr,
  output logic [RF_WIDTH-1:0] dbg_data,
  cpu_ula_issue_if.master     alu
);

  state_e              state_q, state_d;
  logic [15:0]         instr_q, instr_d;
  logic                err_flag_q, err_flag_d;
  logic [RF_WIDTH-1:0] result_q, result_d;
  logic                ready_q, ready_d;
  logic [2:0]          op_code_q, op_code_d;
  logic [RF_WIDTH-1:0] src1_q, src1_d;
  logic [RF_WIDTH-1:0] src2_q, src2_d;
  logic                retire_q, retire_d;
  logic                err_q, err_d;
`ifdef CPU_ULA_ISSUE_TIMEOUT_EN
  logic [3:0]          cnt_q, cnt_d;
`endif

  logic [RF_WIDTH-1:0] rf_rdata_a, rf_rdata_b;

  // Operands are read with the instruction being accepted (instr_d), so the
  // sources are ready to drive during ISSUE; a WB write always lands first.
  cpu_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (state_q == S_WB),
    .waddr    (instr_q[RD_MSB:RD_LSB]),
    .wdata    (result_q),
    .raddr_a  (instr_d[RS1_MSB:RS1_LSB]),
    .raddr_b  (instr_d[RS2_MSB:RS2_LSB]),
    .dbg_addr (dbg_addr),
    .rdata_a  (rf_rdata_a),
    .rdata_b  (rf_rdata_b),
    .dbg_data (dbg_data)
  );

  // Next state, and registered outputs decoded from the next state
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    err_flag_d = err_flag_q;
    result_d   = result_q;
    op_code_d  = OP_NOP;
    src1_d     = src1_q;
    src2_d     = src2_q;
`ifdef CPU_ULA_ISSUE_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d    = instr;
          err_flag_d = 1'b0;
          if (is_alu_op(instr[OP_MSB:OP_LSB])) begin
            state_d = S_ISSUE;
          end else begin
            state_d    = S_DONE;
            err_flag_d = (instr[OP_MSB:OP_LSB] != OP_NOP);
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef CPU_ULA_ISSUE_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        // alu_done takes priority over the terminal count
        if (alu.alu_done) begin
          result_d = alu.alu_result;
          state_d  = S_WB;
        end
`ifdef CPU_ULA_ISSUE_TIMEOUT_EN
        else if (cnt_q + 4'd1 == 4'(TIMEOUT)) begin
          state_d    = S_DONE;
          err_flag_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
`endif
      end
      S_WB:    state_d = S_IDLE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Opcode is nonzero only in ISSUE; sources are then held until the next one
    if (state_d == S_ISSUE) begin
      op_code_d = instr_d[OP_MSB:OP_LSB];
      src1_d    = rf_rdata_a;
      src2_d    = uses_imm(instr_d[OP_MSB:OP_LSB]) ?
                  {9'b0, instr_d[IMM_MSB:IMM_LSB]} : rf_rdata_b;
    end
    ready_d  = (state_d == S_IDLE);
    retire_d = (state_d == S_WB) || (state_d == S_DONE);
    err_d    = (state_d == S_DONE) && err_flag_d;
  end

  // State and output registers; reset drops everything in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      err_flag_q <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b1;
      op_code_q  <= OP_NOP;
      src1_q     <= '0;
      src2_q     <= '0;
      retire_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      err_flag_q <= err_flag_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
      op_code_q  <= op_code_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      retire_q   <= retire_d;
      err_q      <= err_d;
    end
  end

`ifdef CPU_ULA_ISSUE_TIMEOUT_EN
  // WAIT watchdog counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign instr_ready     = ready_q;
  assign retire          = retire_q;
  assign err             = err_q;
  assign alu.alu_op_code = op_code_q;
  assign alu.alu_src1    = src1_q;
  assign alu.alu_src2    = src2_q;

endmodule

// File: tb/tb_cpu_ula_issue.sv
// tb_cpu_ula_issue: directed vectors for cpu_ula_issue with a small ALU stub
// that answers with alu_done two cycles after sampling a nonzero opcode.
// Watchdog vectors depend on CPU_ULA_ISSUE_TIMEOUT_EN.
module tb_cpu_ula_issue;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready, retire, err;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  int n_vec = 0;
  int n_err = 0;

  cpu_ula_issue_if bus ();

  cpu_ula_issue #(.TIMEOUT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .retire      (retire),
    .err         (err),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .alu         (bus)
  );

  always #5 clk = ~clk;

  // ---------------- ALU stub ----------------
  logic        alu_en = 1'b1;
  logic        pend = 1'b0;
  logic [15:0] res_s = '0;
  logic [2:0]  op_s;
  logic [15:0] a_s, b_s;

  function automatic logic [15:0] alu_model(input logic [2:0] op,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
    logic [15:0] mag;
    logic [15:0] r;
    mag = {10'b0, b[5:0]};
    case (op)
      3'b001:  r = a + b;
      3'b010:  r = b[6] ? a - mag : a + mag;
      3'b011:  r = a - b;
      3'b100:  r = b[6] ? a + mag : a - mag;
      3'b101:  r = a * b;
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    op_s = bus.alu_op_code;
    a_s  = bus.alu_src1;
    b_s  = bus.alu_src2;
    #1;
    if (!reset) begin
      bus.alu_done = 1'b0;
      pend = 1'b0;
    end else begin
      bus.alu_done   = pend;
      bus.alu_result = pend ? res_s : 16'hDEAD;
      pend  = (op_s != 3'b000) && alu_en;
      res_s = alu_model(op_s, a_s, b_s);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic logic [15:0] enc_r(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 4'b0000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [6:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  task automatic check_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // Present one instruction (caller sits at a negedge) and follow it to retire
  task automatic send(input logic [15:0] w, output int lat, output logic e,
                      output int opc, output logic [15:0] s1, output logic [15:0] s2);
    int n;
    n = 0;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    instr = w;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr = '0;
    lat = 1; opc = 0; s1 = '0; s2 = '0;
    while (!retire && lat < 40) begin
      if (bus.alu_op_code != 3'b000) begin
        opc++;
        s1 = bus.alu_src1;
        s2 = bus.alu_src2;
      end
      @(negedge clk);
      lat++;
    end
    e = err;
  endtask

  task automatic run(input string tag, input logic [15:0] w, input int exp_lat,
                     input logic exp_err, input int exp_opc,
                     input logic [15:0] exp_s1, input logic [15:0] exp_s2);
    int lat, opc;
    logic e;
    logic [15:0] s1, s2;
    send(w, lat, e, opc, s1, s2);
    check({tag, " retire latency"}, 16'(lat), 16'(exp_lat));
    check({tag, " err"}, {15'b0, e}, {15'b0, exp_err});
    check({tag, " opcode cycles"}, 16'(opc), 16'(exp_opc));
    check({tag, " src1"}, s1, exp_s1);
    check({tag, " src2"}, s2, exp_s2);
    check({tag, " ready at retire"}, {15'b0, instr_ready}, 16'h0000);
    @(negedge clk);
    check({tag, " ready after"}, {15'b0, instr_ready}, 16'h0001);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n_ret;
    int k;
    bus.alu_done   = 1'b0;
    bus.alu_result = '0;

    repeat (2) @(negedge clk);
    check("reset instr_ready", {15'b0, instr_ready}, 16'h0001);
    check("reset op_code", {13'b0, bus.alu_op_code}, 16'h0000);
    check("reset src1", bus.alu_src1, 16'h0000);
    check("reset src2", bus.alu_src2, 16'h0000);
    check("reset retire", {15'b0, retire}, 16'h0000);
    check("reset err", {15'b0, err}, 16'h0000);
    check_reg("reset R7", 3'd7, 16'h0000);
    reset = 1'b1;
    @(negedge clk);

    run("ADDI R1,R0,+5", enc_i(OP_ADDI, 3'd1, 3'd0, 7'h05), 4, 1'b0, 1, 16'h0000, 16'h0005);
    check_reg("R1", 3'd1, 16'h0005);
    run("ADD R2,R1,R1", enc_r(OP_ADD, 3'd2, 3'd1, 3'd1), 4, 1'b0, 1, 16'h0005, 16'h0005);
    check_reg("R2", 3'd2, 16'h000A);
    run("SUBI R3,R1,-3", enc_i(OP_SUBI, 3'd3, 3'd1, 7'h43), 4, 1'b0, 1, 16'h0005, 16'h0043);
    check_reg("R3", 3'd3, 16'h0008);
    run("ADDI R4,R0,16", enc_i(OP_ADDI, 3'd4, 3'd0, 7'h10), 4, 1'b0, 1, 16'h0000, 16'h0010);
    run("MUL R4,R4,R4", enc_r(OP_MUL, 3'd4, 3'd4, 3'd4), 4, 1'b0, 1, 16'h0010, 16'h0010);
    check_reg("R4", 3'd4, 16'h0100);
    run("ADD R5,R4,R0", enc_r(OP_ADD, 3'd5, 3'd4, 3'd0), 4, 1'b0, 1, 16'h0100, 16'h0000);
    check_reg("R5", 3'd5, 16'h0100);
    run("ADDI R6,R0,1", enc_i(OP_ADDI, 3'd6, 3'd0, 7'h01), 4, 1'b0, 1, 16'h0000, 16'h0001);
    check_reg("R6 pre", 3'd6, 16'h0001);
    run("MUL R6,R4,R5", enc_r(OP_MUL, 3'd6, 3'd4, 3'd5), 4, 1'b0, 1, 16'h0100, 16'h0100);
    check_reg("R6 wrap", 3'd6, 16'h0000);
    run("ADD R0,R1,R1", enc_r(OP_ADD, 3'd0, 3'd1, 3'd1), 4, 1'b0, 1, 16'h0005, 16'h0005);
    check_reg("R0", 3'd0, 16'h0000);
    run("illegal 111", enc_r(3'b111, 3'd2, 3'd1, 3'd1), 1, 1'b1, 0, 16'h0000, 16'h0000);
    run("NOP", enc_r(OP_NOP, 3'd3, 3'd1, 3'd1), 1, 1'b0, 0, 16'h0000, 16'h0000);
    check_reg("R2 unchanged", 3'd2, 16'h000A);
    check_reg("R3 unchanged", 3'd3, 16'h0008);

`ifdef CPU_ULA_ISSUE_TIMEOUT_EN
    alu_en = 1'b0;
    run("timeout ADD R7", enc_r(OP_ADD, 3'd7, 3'd1, 3'd1), 10, 1'b1, 1, 16'h0005, 16'h0005);
    check_reg("R7 no write", 3'd7, 16'h0000);
    k = 3;
`else
    k = 20;
`endif

    // Stalled instruction, then reset while it sits in WAIT
    alu_en = 1'b0;
    instr = enc_r(OP_ADD, 3'd7, 3'd1, 3'd1);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr = '0;
    n_ret = 0;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      if (retire) n_ret++;
    end
    check("stalled retires", 16'(n_ret), 16'h0000);
    check("stalled src1", bus.alu_src1, 16'h0005);
    #2;
    reset = 1'b0;
    #1;
    check("midreset instr_ready", {15'b0, instr_ready}, 16'h0001);
    check("midreset op_code", {13'b0, bus.alu_op_code}, 16'h0000);
    check("midreset src1", bus.alu_src1, 16'h0000);
    check("midreset src2", bus.alu_src2, 16'h0000);
    check("midreset retire", {15'b0, retire}, 16'h0000);
    check("midreset err", {15'b0, err}, 16'h0000);
    check_reg("midreset R1", 3'd1, 16'h0000);
    check_reg("midreset R2", 3'd2, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    alu_en = 1'b1;
    n_ret = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (retire) n_ret++;
    end
    check("post-reset retires", 16'(n_ret), 16'h0000);
    run("ADDI R1,R0,+3", enc_i(OP_ADDI, 3'd1, 3'd0, 7'h03), 4, 1'b0, 1, 16'h0000, 16'h0003);
    check_reg("R1 after reset", 3'd1, 16'h0003);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
